instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch stage feeding the combinational instruction memory.
- Owns the 64-bit program counter and drives the memory read address.
- Captures each returned 32-bit word with its PC into a small fetch queue.
- Presents the queue head to the decode stage through a valid/ready handshake, and takes branch redirects from downstream.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
QUEUE_DEPTH, 2, fetch-queue entries; must be a power of two, at least 2

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
readAddress  output  64  instruction memory read address; equals the PC register
instruction  input  32  word returned combinationally by instruction memory for readAddress
fetchEnable  input  1  1 = fetch allowed this cycle; 0 = PC frozen, no enqueue
branchTaken  input  1  redirect request, sampled on the clock edge
branchTarget  input  64  redirect destination
fetchValid  output  1  queue head holds a valid instruction
fetchReady  input  1  decode accepts the head this cycle
fetchInstruction  output  32  instruction at the queue head
fetchPC  output  64  PC of the queue head
queueFull  output  1  count == QUEUE_DEPTH

Behaviour:
- State consists of:
  - PC register.
  - Circular queue of {PC, instruction} entries with head pointer, tail pointer and count (0..QUEUE_DEPTH).
  - All of it is reset asynchronously when reset_n = 0.
- Reset values:
  - PC = RESET_PC, so readAddress = RESET_PC.
  - count = 0, pointers = 0.
  - fetchValid = 0, queueFull = 0, fetchInstruction = 0, fetchPC = 0.
- Reset asserted mid-operation discards all queue contents immediately, without waiting for a clock edge.
- Per-cycle definitions:
  - deq = fetchValid & fetchReady.
  - enq = fetchEnable & ~branchTaken & (count < QUEUE_DEPTH | deq).
- Enqueue (on the edge when enq = 1):
  - Write {PC, instruction} at tail; advance tail, wrapping modulo QUEUE_DEPTH.
  - PC <= PC + 4. PC arithmetic is modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- Dequeue (on the edge when deq = 1 and branchTaken = 0):
  - Advance head, wrapping.
- Count update:
  - Simultaneous enq and deq leaves count unchanged. This is legal when full: the entry freed by deq is reused the same edge.
- Outputs:
  - fetchValid = (count != 0).
  - fetchInstruction / fetchPC = head entry when count != 0, else 0.
  - Outputs are driven from registers only; there is no combinational path from instruction to fetch* outputs.
- Latency:
  - A word addressed at edge N appears on fetchInstruction after edge N+1 (one cycle), given an empty queue.
- Stall:
  - fetchReady = 0 with fetchEnable = 1 fills the queue to QUEUE_DEPTH.
  - From then on PC holds and readAddress is stable until a dequeue frees space.
- Halt:
  - fetchEnable = 0 freezes PC; queued entries still drain normally.
- Redirect (branchTaken = 1 at an edge) has top priority:
  - Flush: count = 0, head = tail = 0.
  - PC <= {branchTarget[63:2], 2'b00}. Low two bits are forced to zero with no fault.
  - No enqueue on that edge.
  - A handshake asserted in the same cycle is void: decode must discard its head on a redirect cycle.
  - fetchValid = 0 in the following cycle.
  - The target word appears one cycle later again, when fetchEnable = 1.
- Back-to-back redirects: the last one wins; the queue stays empty until the first non-redirect enqueue edge.
- Misaligned RESET_PC is not supported; the integrator guarantees RESET_PC[1:0] = 0.

Test Plan:
Bench memory preload: 0:8B1F03E5, 4:F84000A4, 8:8B040086, 12:F80010A6. Default inputs: fetchEnable = 1, fetchReady = 1.
- Reset release, streaming -> readAddress goes 0, 4, 8, 12 on successive cycles. fetchValid rises one cycle after release. Outputs (fetchPC, fetchInstruction) read (0, 8B1F03E5), (4, F84000A4), (8, 8B040086), (12, F80010A6) in consecutive cycles.
- fetchReady = 0 from the first edge for 5 cycles -> count reaches 2 and queueFull = 1. readAddress holds at 8. Head stays (0, 8B1F03E5). After fetchReady = 1, entries drain in order 0, 4, 8 with no word lost or duplicated.
- Full queue with fetchReady = 1 for exactly 1 cycle -> entry 0 is accepted and word 8 is enqueued on the same edge. queueFull stays 1; PC advances to 12.
- branchTaken = 1, branchTarget = 64'h7 while the queue holds 2 entries -> next cycle fetchValid = 0 and readAddress = 4. The cycle after, the head is (4, F84000A4).
- fetchEnable = 0 for 3 cycles mid-stream -> readAddress is constant, the queue drains to empty and fetchValid = 0. Resuming continues from the held PC without skipping.
- reset_n pulsed low asynchronously between edges while full -> fetchValid, fetchPC and fetchInstruction go to 0 immediately, and readAddress = RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, branch redirect input and the
// valid/ready handshake towards decode.
interface instruction_fetch_unit_if;
   logic [63:0] readAddress;
   logic [31:0] instruction;
   logic        fetchEnable;
   logic        branchTaken;
   logic [63:0] branchTarget;
   logic        fetchValid;
   logic        fetchReady;
   logic [31:0] fetchInstruction;
   logic [63:0] fetchPC;
   logic        queueFull;

   modport master (
      output readAddress,
      input  instruction,
      input  fetchEnable,
      input  branchTaken,
      input  branchTarget,
      output fetchValid,
      input  fetchReady,
      output fetchInstruction,
      output fetchPC,
      output queueFull
   );

   modport slave (
      input  readAddress,
      output instruction,
      output fetchEnable,
      output branchTaken,
      output branchTarget,
      input  fetchValid,
      output fetchReady,
      input  fetchInstruction,
      input  fetchPC,
      input  queueFull
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational instruction memory and
// buffers {PC, word} pairs in a small circular queue in front of decode.
module instruction_fetch_unit #(
   parameter logic [63:0] RESET_PC    = 64'h0,
   parameter int          QUEUE_DEPTH = 2
) (
   input logic                      clock,
   input logic                      reset_n,
   instruction_fetch_unit_if.master bus
);
   localparam int               PTR_W   = $clog2(QUEUE_DEPTH);
   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

   logic [63:0]      pc;
   logic [63:0]      pc_q  [QUEUE_DEPTH];
   logic [31:0]      ins_q [QUEUE_DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             not_empty;
   logic             deq;
   logic             enq;

   assign not_empty = (count != '0);
   assign deq       = not_empty & bus.fetchReady;
   // A full queue may still accept a word when the head leaves on the same edge.
   assign enq       = bus.fetchEnable & ~bus.branchTaken & ((count < DEPTH_C) | deq);

   assign bus.readAddress      = pc;
   assign bus.fetchValid       = not_empty;
   assign bus.queueFull        = (count == DEPTH_C);
   assign bus.fetchPC          = not_empty ? pc_q[head]  : '0;
   assign bus.fetchInstruction = not_empty ? ins_q[head] : '0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc    <= RESET_PC;
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            pc_q[i]  <= '0;
            ins_q[i] <= '0;
         end
      end else if (bus.branchTaken) begin
         // Redirect flushes everything, including a handshake in the same cycle.
         pc    <= bus.branchTarget & ~64'h3;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) begin
            pc_q[tail]  <= pc;
            ins_q[tail] <= bus.instruction;
            tail        <= tail + PTR_W'(1);
            pc          <= pc + 64'd4;
         end
         if (deq) begin
            head <= head + PTR_W'(1);
         end
         if (enq && !deq) begin
            count <= count + CNT_W'(1);
         end else if (deq && !enq) begin
            count <= count - CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, async-reset sequence
// and randomized traffic against a queue-based reference model.
module tb_instruction_fetch_unit;
   localparam int          DEPTH = 2;
   localparam logic [63:0] RPC   = 64'h0;

   logic clock;
   logic reset_n;
   int   total;
   int   bad;

   instruction_fetch_unit_if bus ();

   instruction_fetch_unit #(
      .RESET_PC    (RPC),
      .QUEUE_DEPTH (DEPTH)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      case (a)
         64'd0:   return 32'h8B1F03E5;
         64'd4:   return 32'hF84000A4;
         64'd8:   return 32'h8B040086;
         64'd12:  return 32'hF80010A6;
         default: return a[31:0] ^ 32'h5A5A_5A5A;
      endcase
   endfunction

   assign bus.instruction = mem_word(bus.readAddress);

   typedef struct {
      logic [63:0] pc;
      logic [31:0] ins;
   } ent_t;

   logic [63:0] m_pc;
   ent_t        mq[$];

   typedef struct {
      bit          rst;
      logic        en;
      logic        rdy;
      logic        br;
      logic [63:0] tgt;
      logic [63:0] e_addr;
      logic        e_vld;
      logic [63:0] e_pc;
      logic [31:0] e_ins;
      logic        e_full;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: queue of fetched words, updated from the rules once per edge.
   task automatic model_edge();
      bit deq;
      bit enq;
      deq = (mq.size() != 0) && bus.fetchReady;
      if (bus.branchTaken) begin
         mq.delete();
         m_pc = bus.branchTarget & ~64'h3;
      end else begin
         enq = bus.fetchEnable && ((mq.size() < DEPTH) || deq);
         if (deq) void'(mq.pop_front());
         if (enq) begin
            mq.push_back('{pc: m_pc, ins: mem_word(m_pc)});
            m_pc = m_pc + 64'd4;
         end
      end
   endtask

   task automatic model_check(input string tag);
      ent_t h;
      h = '{pc: 64'h0, ins: 32'h0};
      if (mq.size() != 0) h = mq[0];
      chk({tag, "_m_addr"}, bus.readAddress, m_pc);
      chk({tag, "_m_vld"}, 64'(bus.fetchValid), 64'(mq.size() != 0));
      chk({tag, "_m_pc"}, bus.fetchPC, h.pc);
      chk({tag, "_m_ins"}, 64'(bus.fetchInstruction), 64'(h.ins));
      chk({tag, "_m_full"}, 64'(bus.queueFull), 64'(mq.size() == DEPTH));
   endtask

   task automatic step(input string tag);
      @(posedge clock);
      model_edge();
      #1;
      model_check(tag);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      mq.delete();
      m_pc = RPC;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      chk("rst_addr", bus.readAddress, RPC);
      chk("rst_vld", 64'(bus.fetchValid), 64'd0);
      chk("rst_pc", bus.fetchPC, 64'd0);
      chk("rst_ins", 64'(bus.fetchInstruction), 64'd0);
      chk("rst_full", 64'(bus.queueFull), 64'd0);
   endtask

   function automatic vec_t v(input bit rst, input logic en, input logic rdy, input logic br,
                              input logic [63:0] tgt, input logic [63:0] a, input logic vld,
                              input logic [63:0] p, input logic [31:0] ins, input logic full);
      vec_t r;
      r = '{rst: rst, en: en, rdy: rdy, br: br, tgt: tgt, e_addr: a, e_vld: vld,
            e_pc: p, e_ins: ins, e_full: full};
      return r;
   endfunction

   initial begin
      total = 0;
      bad   = 0;
      reset_n = 1'b0;
      m_pc = RPC;
      bus.fetchEnable  = 1'b1;
      bus.fetchReady   = 1'b1;
      bus.branchTaken  = 1'b0;
      bus.branchTarget = 64'h0;

      // streaming after reset
      tbl.push_back(v(1, 1, 1, 0, 0, 64'd4,  1, 64'd0,  32'h8B1F03E5, 0));
      tbl.push_back(v(0, 1, 1, 0, 0, 64'd8,  1, 64'd4,  32'hF84000A4, 0));
      tbl.push_back(v(0, 1, 1, 0, 0, 64'd12, 1, 64'd8,  32'h8B040086, 0));
      tbl.push_back(v(0, 1, 1, 0, 0, 64'd16, 1, 64'd12, 32'hF80010A6, 0));
      // stall to full, one-cycle accept while full, halt-drain, resume
      tbl.push_back(v(1, 1, 0, 0, 0, 64'd4,  1, 64'd0,  32'h8B1F03E5, 0));
      tbl.push_back(v(0, 1, 0, 0, 0, 64'd8,  1, 64'd0,  32'h8B1F03E5, 1));
      tbl.push_back(v(0, 1, 0, 0, 0, 64'd8,  1, 64'd0,  32'h8B1F03E5, 1));
      tbl.push_back(v(0, 1, 0, 0, 0, 64'd8,  1, 64'd0,  32'h8B1F03E5, 1));
      tbl.push_back(v(0, 1, 0, 0, 0, 64'd8,  1, 64'd0,  32'h8B1F03E5, 1));
      tbl.push_back(v(0, 1, 1, 0, 0, 64'd12, 1, 64'd4,  32'hF84000A4, 1));
      tbl.push_back(v(0, 0, 1, 0, 0, 64'd12, 1, 64'd8,  32'h8B040086, 0));
      tbl.push_back(v(0, 0, 1, 0, 0, 64'd12, 0, 64'd0,  32'h0,        0));
      tbl.push_back(v(0, 0, 1, 0, 0, 64'd12, 0, 64'd0,  32'h0,        0));
      tbl.push_back(v(0, 1, 1, 0, 0, 64'd16, 1, 64'd12, 32'hF80010A6, 0));
      // redirect with full queue, void handshake, misaligned target
      tbl.push_back(v(1, 1, 0, 0, 0, 64'd4,  1, 64'd0,  32'h8B1F03E5, 0));
      tbl.push_back(v(0, 1, 0, 0, 0, 64'd8,  1, 64'd0,  32'h8B1F03E5, 1));
      tbl.push_back(v(0, 1, 1, 1, 64'h7, 64'd4, 0, 64'd0, 32'h0,      0));
      tbl.push_back(v(0, 1, 1, 0, 0, 64'd8,  1, 64'd4,  32'hF84000A4, 0));
      // back-to-back redirects, last wins, then PC wraps through 2^64
      tbl.push_back(v(0, 1, 1, 1, 64'h40, 64'h40, 0, 64'd0, 32'h0, 0));
      tbl.push_back(v(0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'd0, 32'h0, 0));
      tbl.push_back(v(0, 1, 0, 0, 0, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFC,
                      mem_word(64'hFFFF_FFFF_FFFF_FFFC), 0));
      tbl.push_back(v(0, 1, 0, 0, 0, 64'd4, 1, 64'hFFFF_FFFF_FFFF_FFFC,
                      mem_word(64'hFFFF_FFFF_FFFF_FFFC), 1));

      @(posedge clock);
      #1;
      for (int i = 0; i < tbl.size(); i++) begin
         string t;
         t = $sformatf("vec%0d", i);
         if (tbl[i].rst) do_reset();
         bus.fetchEnable  = tbl[i].en;
         bus.fetchReady   = tbl[i].rdy;
         bus.branchTaken  = tbl[i].br;
         bus.branchTarget = tbl[i].tgt;
         step(t);
         chk({t, "_addr"}, bus.readAddress, tbl[i].e_addr);
         chk({t, "_vld"}, 64'(bus.fetchValid), 64'(tbl[i].e_vld));
         chk({t, "_pc"}, bus.fetchPC, tbl[i].e_pc);
         chk({t, "_ins"}, 64'(bus.fetchInstruction), 64'(tbl[i].e_ins));
         chk({t, "_full"}, 64'(bus.queueFull), 64'(tbl[i].e_full));
      end

      // asynchronous reset between edges while the queue is full
      do_reset();
      bus.fetchEnable = 1'b1;
      bus.fetchReady  = 1'b0;
      bus.branchTaken = 1'b0;
      step("fill0");
      step("fill1");
      step("fill2");
      chk("pre_arst_full", 64'(bus.queueFull), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_vld", 64'(bus.fetchValid), 64'd0);
      chk("arst_pc", bus.fetchPC, 64'd0);
      chk("arst_ins", 64'(bus.fetchInstruction), 64'd0);
      chk("arst_addr", bus.readAddress, RPC);
      chk("arst_full", 64'(bus.queueFull), 64'd0);
      @(posedge clock);
      #1;

      // randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         logic [63:0] tg;
         bus.fetchEnable = ($urandom_range(7) != 0);
         bus.fetchReady  = ($urandom_range(2) != 0);
         bus.branchTaken = ($urandom_range(11) == 0);
         tg = {$urandom, $urandom};
         if ($urandom_range(3) == 0) tg = {32'hFFFF_FFFF, 28'hFFF_FFFF, tg[3:0]};
         bus.branchTarget = tg;
         step($sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
